// File: rtl/fetch_decode.sv
// fetch_decode: multi-cycle RV32I fetch/decode stage (ADDI/SLTI/XORI/ORI/ANDI/
// SLLI/SRLI, ADD/SUB/SLL/SLT/XOR/SRL/OR/AND, BEQ/BNE) with a valid/ready fetch port.
// Define FETCH_DECODE_INSTRET_EN to add the 32-bit retired-instruction counter output.
module fetch_decode #(
  parameter int unsigned          ADDRESS_WIDTH = 5,
  parameter int unsigned          DATA_WIDTH    = 32,
  parameter int unsigned          PC_WIDTH      = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [PC_WIDTH-1:0]      imem_addr,
  input  logic                     imem_ready,
  input  logic                     imem_rvalid,
  input  logic [31:0]              imem_rdata,
  output logic [ADDRESS_WIDTH-1:0] ad1,
  output logic [ADDRESS_WIDTH-1:0] ad2,
  output logic [ADDRESS_WIDTH-1:0] ad3,
  output logic                     we3,
  output logic                     aluSrc,
  output logic [3:0]               aluCTR,
  output logic [DATA_WIDTH-1:0]    immOp,
  input  logic                     eq,
  output logic [PC_WIDTH-1:0]      pc,
  output logic                     illegal
`ifdef FETCH_DECODE_INSTRET_EN
  ,
  output logic [31:0]              instret
`endif
);

  typedef enum logic [2:0] {
    S_RESET_WAIT,
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SLL = 4'b0101,
    ALU_SRL = 4'b0110,
    ALU_SLT = 4'b0111
  } alu_e;

  typedef enum logic [6:0] {
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_BRANCH = 7'b1100011
  } opcode_e;

  state_e              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  logic [31:0]         ir_q;
  logic                req_q;
  logic                ill_q;

  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        dec_we;
  logic        dec_src;
  logic        dec_ill;
  logic        dec_br;
  logic        dec_bne;
  alu_e        dec_ctr;
  logic [31:0] dec_imm;

  logic                exec_ok;
  logic                br_taken;
  logic [PC_WIDTH-1:0] br_target;
  logic                halt_now;

  assign f3 = ir_q[14:12];
  assign f7 = ir_q[31:25];

  // Decode the held instruction word into datapath controls and legality.
  always_comb begin
    dec_we  = 1'b0;
    dec_src = 1'b0;
    dec_ill = 1'b0;
    dec_br  = 1'b0;
    dec_bne = 1'b0;
    dec_ctr = ALU_ADD;
    dec_imm = '0;
    case (ir_q[6:0])
      OP_IMM: begin
        dec_we  = 1'b1;
        dec_src = 1'b1;
        dec_imm = {{20{ir_q[31]}}, ir_q[31:20]};
        case (f3)
          3'b000: dec_ctr = ALU_ADD;
          3'b010: dec_ctr = ALU_SLT;
          3'b100: dec_ctr = ALU_XOR;
          3'b110: dec_ctr = ALU_OR;
          3'b111: dec_ctr = ALU_AND;
          3'b001: begin
            dec_ctr = ALU_SLL;
            dec_imm = {27'd0, ir_q[24:20]};
            dec_ill = (f7 != 7'd0);
          end
          3'b101: begin
            dec_ctr = ALU_SRL;
            dec_imm = {27'd0, ir_q[24:20]};
            dec_ill = (f7 != 7'd0);
          end
          default: dec_ill = 1'b1;
        endcase
      end
      OP_REG: begin
        dec_we = 1'b1;
        case (f3)
          3'b000:  dec_ctr = (f7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
          3'b001:  dec_ctr = ALU_SLL;
          3'b010:  dec_ctr = ALU_SLT;
          3'b100:  dec_ctr = ALU_XOR;
          3'b101:  dec_ctr = ALU_SRL;
          3'b110:  dec_ctr = ALU_OR;
          3'b111:  dec_ctr = ALU_AND;
          default: dec_ill = 1'b1;
        endcase
        if (f7 != 7'd0 && !(f3 == 3'b000 && f7 == 7'b0100000)) begin
          dec_ill = 1'b1;
        end
      end
      OP_BRANCH: begin
        dec_ctr = ALU_SUB;
        dec_imm = {{20{ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
        case (f3)
          3'b000:  dec_br = 1'b1;
          3'b001: begin
            dec_br  = 1'b1;
            dec_bne = 1'b1;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // Controls are a function of registered state/IR only, so they are held
  // to zero outside EXEC and for an illegal word.
  assign exec_ok = (state_q == S_EXEC) && !dec_ill;
  assign ad1     = exec_ok ? ADDRESS_WIDTH'(ir_q[19:15]) : '0;
  assign ad2     = exec_ok ? ADDRESS_WIDTH'(ir_q[24:20]) : '0;
  assign ad3     = exec_ok ? ADDRESS_WIDTH'(ir_q[11:7])  : '0;
  assign we3     = exec_ok & dec_we;
  assign aluSrc  = exec_ok & dec_src;
  assign aluCTR  = exec_ok ? dec_ctr : ALU_ADD;
  assign immOp   = exec_ok ? DATA_WIDTH'(dec_imm) : '0;

  assign br_taken  = dec_br && (eq != dec_bne);
  assign br_target = pc_q + PC_WIDTH'($signed(dec_imm));
  assign pc_d      = br_taken ? br_target : pc_q + PC_WIDTH'(4);
  assign halt_now  = dec_ill || (br_taken && br_target[1]);

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign illegal   = ill_q;

  // Control FSM: fetch handshake, IR capture, PC update and halt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RESET_WAIT;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0000_0013;
      req_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      case (state_q)
        S_RESET_WAIT: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ready) begin
            state_q <= S_WAIT;
            req_q   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            ir_q    <= imem_rdata;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (halt_now) begin
            state_q <= S_HALT;
            ill_q   <= 1'b1;
          end else begin
            pc_q    <= pc_d;
            state_q <= S_FETCH;
            req_q   <= 1'b1;
          end
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_RESET_WAIT;
      endcase
    end
  end

`ifdef FETCH_DECODE_INSTRET_EN
  logic [31:0] instret_q;

  // Count each EXEC cycle that completes without halting.
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
    end else if (state_q == S_EXEC && !halt_now) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  assign instret = instret_q;
`endif

endmodule

// File: doc/fetch_decode.md
# fetch_decode

Instruction fetch and decode stage that sits directly upstream of the register-file/ALU datapath. It holds the program counter and fetches 32-bit RV32I instructions over a valid/ready memory handshake. Each instruction is decoded into the datapath's register addresses, write enable, ALU-source select, ALU control and immediate. Branches are resolved from the datapath's `eq` flag. The block is multi-cycle: at most one instruction is in flight, and the datapath controls are driven for exactly one cycle per instruction.

## Interface
- `ADDRESS_WIDTH`, 5: register address width.
- `DATA_WIDTH`, 32: immediate/data width; must be 32.
- `PC_WIDTH`, 32: program counter width.
- `RESET_PC`, 0: PC value loaded on reset; must be a multiple of 4.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out PC_WIDTH: fetch address, equal to `pc`.
- `imem_ready` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: instruction data valid.
- `imem_rdata` in 32: instruction word.
- `ad1` out ADDRESS_WIDTH: rs1.
- `ad2` out ADDRESS_WIDTH: rs2.
- `ad3` out ADDRESS_WIDTH: rd.
- `we3` out 1: register write enable.
- `aluSrc` out 1: 1 selects `immOp` as ALU operand 2.
- `aluCTR` out 4: ALU operation.
- `immOp` out DATA_WIDTH: sign-extended immediate.
- `eq` in 1: datapath operand equality, combinational from the driven controls.
- `pc` out PC_WIDTH: current PC.
- `illegal` out 1: sticky halt flag.

## Operation
- States:
  - RESET_WAIT: one cycle after reset.
  - FETCH
  - WAIT
  - EXEC
  - HALT
- RESET_WAIT to FETCH: unconditional.
- FETCH:
  - Drives `imem_req`=1 and `imem_addr`=pc.
  - Moves to WAIT on `imem_ready`.
  - `imem_rvalid` is ignored in this state.
- WAIT:
  - `imem_req`=0.
  - On `imem_rvalid`, latches `imem_rdata` into IR and moves to EXEC.
- EXEC, one cycle:
  - Drives controls decoded from IR.
  - Updates `pc` at the end of the cycle.
  - Moves to FETCH, or to HALT on an illegal instruction or a misaligned target.
- HALT:
  - `illegal`=1, all controls 0, PC frozen.
  - Leaves only on reset.
- `aluCTR` encoding: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SLT.
- Decode of opcode 0010011 (ADDI/SLTI/XORI/ORI/ANDI/SLLI/SRLI):
  - `aluSrc`=1, `we3`=1.
  - I-immediate, sign-extended.
  - For shifts, `immOp` carries shamt in the low 5 bits only.
  - SLLI/SRLI with funct7≠0 is illegal.
- Decode of opcode 0110011 (ADD/SUB/SLL/SLT/XOR/SRL/OR/AND):
  - `aluSrc`=0, `we3`=1.
  - funct7 0100000 is valid only with ADD (giving SUB). Any other funct7≠0 is illegal.
- Decode of opcode 1100011 (BEQ/BNE):
  - `aluSrc`=0, `we3`=0, `aluCTR`=SUB.
  - `immOp`=B-immediate.
  - Taken when (`eq` && BEQ) || (!`eq` && BNE), sampled in EXEC.
- All other opcodes and funct3 values are illegal; IR is kept for debug.
- `ad1`, `ad2`, `ad3` always come from IR fields [19:15], [24:20], [11:7].
- Write to x0: `we3` is still asserted; the register file ignores it.
- Next PC is `pc`+4, or `pc`+B-imm when the branch is taken. Arithmetic is modulo 2^PC_WIDTH, so wrap-around is silent.
- A taken branch whose target has bit 1 set goes to HALT with PC unchanged.

## Timing
- Reset values:
  - `pc`=RESET_PC.
  - State RESET_WAIT.
  - `imem_req`=0, `illegal`=0.
  - `we3`=0, `aluSrc`=0, `aluCTR`=0, `immOp`=0, `ad1`/`ad2`/`ad3`=0.
  - IR=0x00000013 (NOP).
- Outside EXEC, all datapath controls are 0.
- Minimum 3 cycles per instruction (FETCH, WAIT, EXEC) with `imem_ready` and `imem_rvalid` each high one cycle after the prior state.
- `imem_req` stays high in FETCH until `imem_ready`; `imem_addr` is stable while requesting.
- Memory must not assert `imem_rvalid` in the same cycle as `imem_ready`.
- Reset mid-operation: rst in any state returns to RESET_WAIT on the next edge. A stale `imem_rvalid` arriving after reset is ignored, because it lands outside WAIT.
- `eq` must settle combinationally within the EXEC cycle; it is used only in EXEC.

## Configuration
- `FETCH_DECODE_INSTRET_EN`:
  - When defined, adds output `instret` (32 bits).
  - Reset value 0; increments once per EXEC cycle that completes without halting; wraps at 2^32.
- When undefined, the port and counter are absent.

## Test plan
- Reset then ADDI x1,x0,5 (0x00500093), zero-wait memory:
  - EXEC on cycle 3 with `ad3`=1, `we3`=1, `aluSrc`=1, `aluCTR`=0000, `immOp`=5.
  - `pc` goes 0 to 4.
- SUB x3,x1,x2 (0x402081B3) → `aluCTR`=0001, `aluSrc`=0, `ad1`=1, `ad2`=2, `ad3`=3.
- BEQ x1,x2,-8 at pc=0x20:
  - With `eq`=1 → `pc`=0x18 and `we3`=0.
  - With `eq`=0 → `pc`=0x24.
- `imem_ready` held low 4 cycles, then `imem_rvalid` delayed 3 cycles:
  - `imem_req` stays high with a stable `imem_addr`.
  - Exactly one EXEC occurs.
- Opcode 0x0000007F:
  - `illegal`=1 the cycle after EXEC, PC frozen, no further `imem_req`.
  - rst clears `illegal` and sets `pc`=RESET_PC.
- rst asserted in WAIT, with `imem_rvalid` pulsed the next cycle → no EXEC, next fetch from RESET_PC. With the macro enabled, `instret` stays 0.
